// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one word-wide main-memory port between the ICache and
//                the DCache. Performs 4-beat line refills (assembled into a
//                128-bit line) and single-word DCache write-through stores,
//                returning a one-cycle ready pulse to the granted cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int WORD       = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    // ICache line-read port
    input  logic                  icache_valid,
    input  logic [WORD-1:0]       icache_addr,
    output logic                  icache_ready,
    output logic [LINE_WIDTH-1:0] icache_data,
    // DCache line-read / store port
    input  logic                  dcache_valid,
    input  logic                  dcache_for_store,
    input  logic [WORD-1:0]       dcache_addr,
    input  logic [WORD-1:0]       dcache_wdata,
    output logic                  dcache_ready,
    output logic [LINE_WIDTH-1:0] dcache_data,
    // Main-memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD-1:0]       mem_addr,
    output logic [WORD-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD-1:0]       mem_rdata
);

    // Beat counter width and byte-offset width of a line.
    localparam int C_BEAT_W = $clog2(LINE_WORDS);
    localparam int C_OFF_W  = C_BEAT_W + 2;

    // State encoding.
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RD   = 2'd1;
    localparam logic [1:0] C_WR   = 2'd2;
    localparam logic [1:0] C_RESP = 2'd3;

    // Owner / last-grant encoding: 0 = ICache, 1 = DCache.
    localparam logic C_OWN_I = 1'b0;
    localparam logic C_OWN_D = 1'b1;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [C_BEAT_W-1:0]   r_beat;
    logic [WORD-1:2]       r_req_addr;   // word address; byte offset is never used
    logic [WORD-1:0]       r_req_wdata;
    logic [LINE_WIDTH-1:0] r_line_buf;

    logic w_any_valid;
    logic w_grant_d;
    logic w_unused;

    // Byte-offset bits of the request addresses carry no information.
    assign w_unused = ^{icache_addr[1:0], dcache_addr[1:0]};

    // Arbitration: on a tie the cache that did not win last time is granted.
    assign w_any_valid = icache_valid | dcache_valid;
    assign w_grant_d   = dcache_valid & (~icache_valid | (r_last_grant == C_OWN_I));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; mem_ack only matters while a memory access is open.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_any_valid) begin
                    if (w_grant_d && dcache_for_store) begin
                        w_next_state = C_WR;
                    end else begin
                        w_next_state = C_RD;
                    end
                end
            end
            C_RD: begin
                if (mem_ack && (r_beat == C_BEAT_W'(LINE_WORDS - 1))) begin
                    w_next_state = C_RESP;
                end
            end
            C_WR: begin
                if (mem_ack) begin
                    w_next_state = C_RESP;
                end
            end
            C_RESP: begin
                w_next_state = C_IDLE;
            end
            default: begin
                w_next_state = C_IDLE;
            end
        endcase
    end

    // Request latching at grant time, beat counting and line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= C_OWN_I;
            r_last_grant <= C_OWN_I;
            r_beat       <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_line_buf   <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_any_valid) begin
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        r_beat       <= '0;
                        r_req_addr   <= w_grant_d ? dcache_addr[WORD-1:2]
                                                  : icache_addr[WORD-1:2];
                        r_req_wdata  <= dcache_wdata;
                    end
                end
                C_RD: begin
                    if (mem_ack) begin
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            if (r_beat == C_BEAT_W'(k)) begin
                                r_line_buf[k*WORD +: WORD] <= mem_rdata;
                            end
                        end
                        // Wraps to zero after the last beat; cleared again at grant.
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        icache_ready = 1'b0;
        dcache_ready = 1'b0;
        case (r_state)
            C_RD: begin
                mem_req  = 1'b1;
                mem_addr = {r_req_addr[WORD-1:C_OFF_W], r_beat, 2'b00};
            end
            C_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_req_addr, 2'b00};
                mem_wdata = r_req_wdata;
            end
            C_RESP: begin
                icache_ready = (r_owner == C_OWN_I);
                dcache_ready = (r_owner == C_OWN_D);
            end
            default: begin
            end
        endcase
    end

    // Both caches see the shared line buffer; only the owner's ready qualifies it.
    assign icache_data = r_line_buf;
    assign dcache_data = r_line_buf;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter: reset, fair
//                arbitration, a table of single transactions, wait-state
//                refill and reset in the middle of a refill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         icache_valid;
    logic [31:0]  icache_addr;
    logic         icache_ready;
    logic [127:0] icache_data;
    logic         dcache_valid;
    logic         dcache_for_store;
    logic [31:0]  dcache_addr;
    logic [31:0]  dcache_wdata;
    logic         dcache_ready;
    logic [127:0] dcache_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    // Memory model: zero-wait (ack whenever requested) or manually driven ack.
    // Read data equals the word address being read.
    logic man_mode;
    logic ack_man;
    assign mem_ack   = man_mode ? ack_man : mem_req;
    assign mem_rdata = mem_addr;

    int checks   = 0;
    int failures = 0;

    cache_mem_arbiter #(.WORD(32), .LINE_WORDS(4), .LINE_WIDTH(128)) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_valid     (icache_valid),
        .icache_addr      (icache_addr),
        .icache_ready     (icache_ready),
        .icache_data      (icache_data),
        .dcache_valid     (dcache_valid),
        .dcache_for_store (dcache_for_store),
        .dcache_addr      (dcache_addr),
        .dcache_wdata     (dcache_wdata),
        .dcache_ready     (dcache_ready),
        .dcache_data      (dcache_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         use_d;
        logic         store;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_addr0;
        logic [127:0] exp_line;
        int           exp_rdy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with zero-wait memory; cycle 0 is an IDLE cycle.
    task automatic run_txn(input vec_t v);
        int  cyc;
        int  beats;
        bit  got;
        cyc   = 0;
        beats = 0;
        got   = 1'b0;
        tick();
        icache_valid     = ~v.use_d;
        dcache_valid     = v.use_d;
        dcache_for_store = v.store;
        icache_addr      = v.addr;
        dcache_addr      = v.addr;
        dcache_wdata     = v.wdata;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (mem_req) begin
                chk("txn_we", mem_we, v.store);
                chk("txn_addr", mem_addr, v.exp_addr0 + 32'(4 * beats));
                if (v.store) chk("txn_wdata", mem_wdata, v.wdata);
                beats++;
            end
            if (v.use_d ? icache_ready : dcache_ready)
                chk("txn_wrong_ready", 1'b1, 1'b0);
            if (v.use_d ? dcache_ready : icache_ready) begin
                got = 1'b1;
                chk("txn_ready_cycle", cyc, v.exp_rdy);
                chk("txn_line", v.use_d ? dcache_data : icache_data, v.exp_line);
                chk("txn_beats", beats, v.store ? 1 : 4);
            end
        end
        if (!got) chk("txn_timeout", 1'b0, 1'b1);
        icache_valid = 1'b0;
        dcache_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] order_d;
        int nrdy;
        int acks;
        bit got;

        vecs[0] = '{1'b0, 1'b0, 32'h1C00_0014, 32'h0, 32'h1C00_0010,
                    128'h1C00001C_1C000018_1C000014_1C000010, 5};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_100B, 32'hDEAD_BEEF, 32'h0000_1008,
                    128'h1C00001C_1C000018_1C000014_1C000010, 2};
        vecs[2] = '{1'b1, 1'b0, 32'hABCD_EF7F, 32'h0, 32'hABCD_EF70,
                    128'hABCDEF7C_ABCDEF78_ABCDEF74_ABCDEF70, 5};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_000F, 32'h0, 32'h0000_0000,
                    128'h0000000C_00000008_00000004_00000000, 5};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFC,
                    128'h0000000C_00000008_00000004_00000000, 2};

        man_mode = 1'b0; ack_man = 1'b0;
        icache_valid = 1'b0; dcache_valid = 1'b0; dcache_for_store = 1'b0;
        icache_addr = 32'h0000_0100; dcache_addr = 32'h0000_0200; dcache_wdata = 32'h0;

        // Reset held two cycles with both requesters active.
        rst = 1'b1;
        icache_valid = 1'b1;
        dcache_valid = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_readies", {icache_ready, dcache_ready}, 2'b00);
        chk("rst_icache_data", icache_data, 128'h0);
        chk("rst_dcache_data", dcache_data, 128'h0);
        rst = 1'b0;

        // Continuous contention: expect alternating D, I, D, I.
        order_d = 4'b0;
        nrdy = 0;
        for (int c = 0; c < 60 && nrdy < 4; c++) begin
            tick();
            if (icache_ready && dcache_ready) chk("both_ready", 1'b1, 1'b0);
            if (dcache_ready) begin
                chk("rr_d_line", dcache_data, 128'h0000020C_00000208_00000204_00000200);
                order_d[nrdy] = 1'b1;
                nrdy++;
            end else if (icache_ready) begin
                chk("rr_i_line", icache_data, 128'h0000010C_00000108_00000104_00000100);
                nrdy++;
            end
        end
        icache_valid = 1'b0;
        dcache_valid = 1'b0;
        chk("rr_count", nrdy, 4);
        chk("rr_order_dfirst", order_d, 4'b0101);

        // Table of isolated transactions.
        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Wait-state refill: ack only on cycles 3, 6, 9, 12.
        man_mode = 1'b1;
        tick();
        icache_valid = 1'b1;
        icache_addr  = 32'h0000_5550;
        acks = 0;
        got  = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ack_man = (c % 3 == 0);
            if (!got && c < 13) begin
                chk("ws_req", mem_req, 1'b1);
                chk("ws_addr", mem_addr, 32'h0000_5550 + 32'(4 * acks));
            end
            if (mem_req && ack_man) acks++;
            if (dcache_ready) chk("ws_wrong_ready", 1'b1, 1'b0);
            if (icache_ready) begin
                got = 1'b1;
                icache_valid = 1'b0;
                chk("ws_ready_cycle", c, 13);
                chk("ws_line", icache_data, 128'h0000555C_00005558_00005554_00005550);
            end
        end
        if (!got) chk("ws_timeout", 1'b0, 1'b1);
        ack_man = 1'b0;
        icache_valid = 1'b0;

        // Reset during beat 2 of an ICache refill, then a late ack.
        tick();
        icache_valid = 1'b1;
        icache_addr  = 32'h0000_3000;
        tick(); ack_man = 1'b1;
        tick(); ack_man = 1'b1;
        tick(); ack_man = 1'b0;
        chk("mid_beat2_addr", mem_addr, 32'h0000_3008);
        rst = 1'b1;
        icache_valid = 1'b0;
        tick();
        rst = 1'b0;
        ack_man = 1'b1;
        chk("mid_req_dropped", mem_req, 1'b0);
        chk("mid_line_cleared", icache_data, 128'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_no_req", mem_req, 1'b0);
            chk("mid_no_ready", {icache_ready, dcache_ready}, 2'b00);
        end
        ack_man  = 1'b0;
        man_mode = 1'b0;
        run_txn('{1'b1, 1'b0, 32'h0000_4444, 32'h0, 32'h0000_4440,
                  128'h0000444C_00004448_00004444_00004440, 5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
